// File: rtl/nes_pkg.sv
// Shared constants and FSM state type for the NES pad responder.
// Button bit positions follow the order the 4021 shifts them out.
package nes_pkg;

    localparam int NES_BITS  = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } nes_state_e;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe, followed by a registered
// level and rise/fall detection on that registered level.
module nes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;
    logic                   r_lvl_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_lvl   <= r_sync[SYNC_STAGES-1];
            r_lvl_d <= r_lvl;
        end
    end

    assign o_level = r_lvl;
    assign o_rise  = r_lvl & ~r_lvl_d;
    assign o_fall  = ~r_lvl & r_lvl_d;

endmodule

// File: rtl/nes_pad_responder.sv
// Controller-side NES pad emulation: a 4021-style latch/shift responder.
// Optional A/B turbo is enabled with the NES_RESP_TURBO_EN macro.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for a latch; pulses ignored
//   ST_LOAD  | synced latch high; shreg tracks ~buttons every cycle
//   ST_SHIFT | latch released, fewer than 8 bits shifted
//   ST_DONE  | 8 bits shifted; output holds POST_FILL
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic POST_FILL   = 1'b1
) (
    input  logic                clk,
    input  logic                hard_reset,
    input  logic [NES_BITS-1:0] buttons,
    input  logic [1:0]          turbo_mask,
    input  logic                nes_latch,
    input  logic                nes_pulse,
    output logic                nes_data,
    output logic                busy,
    output logic                frame_done
);

    logic w_latch_level, w_latch_rise, w_latch_fall;
    logic w_pulse_level, w_pulse_rise, w_pulse_fall;

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .i_clk   (clk),
        .i_rst   (hard_reset),
        .i_async (nes_latch),
        .o_level (w_latch_level),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pulse (
        .i_clk   (clk),
        .i_rst   (hard_reset),
        .i_async (nes_pulse),
        .o_level (w_pulse_level),
        .o_rise  (w_pulse_rise),
        .o_fall  (w_pulse_fall)
    );

    logic w_unused_edges;
    assign w_unused_edges = w_latch_rise ^ w_pulse_level ^ w_pulse_fall;

    logic [NES_BITS-1:0] w_pressed;

`ifdef NES_RESP_TURBO_EN
    logic r_phase;

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            r_phase <= 1'b0;
        end else if (w_latch_fall) begin
            r_phase <= ~r_phase;
        end
    end

    // Turbo-enabled buttons only report pressed on odd-phase frames.
    always_comb begin
        w_pressed        = buttons;
        w_pressed[BTN_A] = buttons[BTN_A] & (~turbo_mask[0] | r_phase);
        w_pressed[BTN_B] = buttons[BTN_B] & (~turbo_mask[1] | r_phase);
    end
`else
    logic w_unused_turbo;
    assign w_unused_turbo = ^turbo_mask;
    assign w_pressed      = buttons;
`endif

    nes_state_e          r_state,   w_state_nxt;
    logic [NES_BITS-1:0] r_shreg,   w_shreg_nxt;
    logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_fdone,   w_fdone_nxt;

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '1;
            r_bit_cnt <= 4'd0;
            r_busy    <= 1'b0;
            r_fdone   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_fdone   <= w_fdone_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_busy_nxt    = r_busy;
        w_fdone_nxt   = 1'b0;

        // A held latch overrides everything, including a coincident pulse edge.
        if (w_latch_level) begin
            w_state_nxt   = ST_LOAD;
            w_shreg_nxt   = ~w_pressed;
            w_bit_cnt_nxt = 4'd0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_latch_fall) begin
                        w_state_nxt = ST_SHIFT;
                        w_busy_nxt  = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_pulse_rise) begin
                        w_shreg_nxt   = {POST_FILL, r_shreg[NES_BITS-1:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(NES_BITS - 1)) begin
                            w_state_nxt = ST_DONE;
                            w_busy_nxt  = 1'b0;
                            w_fdone_nxt = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_pulse_rise) begin
                        w_shreg_nxt = {POST_FILL, r_shreg[NES_BITS-1:1]};
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign nes_data   = r_shreg[0];
    assign busy       = r_busy;
    assign frame_done = r_fdone;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: directed and randomized frames
// compared against a frame-level model of the pad's serial output.
module tb_nes_pad_responder;

    localparam int   SYNC = 2;
    localparam logic PF   = 1'b1;
`ifdef NES_RESP_TURBO_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       hard_reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic [1:0] turbo_mask = 2'b00;
    logic       nes_latch = 1'b0;
    logic       nes_pulse = 1'b0;
    logic       nes_data, busy, frame_done;

    int checks = 0;
    int errors = 0;
    bit model_phase = 1'b0;

    always #5 clk = ~clk;

    nes_pad_responder #(.SYNC_STAGES(SYNC), .POST_FILL(PF)) dut (
        .clk        (clk),
        .hard_reset (hard_reset),
        .buttons    (buttons),
        .turbo_mask (turbo_mask),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .nes_data   (nes_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Serial frame expected from the pad: bit k is ~pressed[k], turbo gating A/B.
    function automatic logic [7:0] expect_serial(logic [7:0] btn, logic [1:0] mask, bit phase);
        logic [7:0] pressed;
        pressed = btn;
        if (TURBO) begin
            if (mask[0] && !phase) pressed[0] = 1'b0;
            if (mask[1] && !phase) pressed[1] = 1'b0;
        end
        return ~pressed;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input int hi);
        nes_latch = 1'b1;
        tick(hi);
        nes_latch = 1'b0;
        model_phase = ~model_phase;
        tick(6);
    endtask

    task automatic do_pulse(output int fd_cnt, output logic fd_data);
        fd_cnt  = 0;
        fd_data = 1'bx;
        nes_pulse = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) nes_pulse = 1'b0;
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_data = nes_data;
            end
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] btn,
                             input logic [1:0] mask, input bit change_mid);
        logic [7:0] exp;
        int         fd;
        logic       fdd;
        logic       fd_data_seen;
        int         fd_total;
        fd_total     = 0;
        fd_data_seen = 1'bx;
        buttons    = btn;
        turbo_mask = mask;
        exp = expect_serial(btn, mask, model_phase);
        do_latch(12);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_latch got=%b want=1", name, busy);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (nes_data !== exp[k]) begin
                errors++;
                $display("FAIL %s bit%0d got=%b want=%b", name, k, nes_data, exp[k]);
            end
            if (change_mid && k == 3) buttons = ~btn;
            do_pulse(fd, fdd);
            fd_total += fd;
            if (fd != 0) fd_data_seen = fdd;
        end
        checks++;
        if (fd_total != 1) begin
            errors++;
            $display("FAIL %s frame_done_count got=%0d want=1", name, fd_total);
        end
        checks++;
        if (fd_data_seen !== PF) begin
            errors++;
            $display("FAIL %s data_at_frame_done got=%b want=%b", name, fd_data_seen, PF);
        end
        checks++;
        if (busy !== 1'b0 || nes_data !== PF) begin
            errors++;
            $display("FAIL %s after_frame busy/data got=%b%b want=0%b", name, busy, nes_data, PF);
        end
        do_pulse(fd, fdd);
        checks++;
        if (nes_data !== PF || fd != 0) begin
            errors++;
            $display("FAIL %s extra_pulse data=%b fd=%0d want data=%b fd=0", name, nes_data, fd, PF);
        end
    endtask

    task automatic test_reset();
        hard_reset = 1'b1;
        buttons = 8'h00;
        tick(3);
        hard_reset = 1'b0;
        model_phase = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (nes_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d data/busy/fd got=%b%b%b want=100", i, nes_data, busy, frame_done);
            end
        end
    endtask

    task automatic test_latency();
        buttons    = 8'b1000_0101;
        turbo_mask = 2'b00;
        nes_latch  = 1'b1;
        tick(SYNC + 1);
        checks++;
        if (nes_data !== 1'b1) begin
            errors++;
            $display("FAIL latch_latency_early got=%b want=1", nes_data);
        end
        tick(1);
        checks++;
        if (nes_data !== 1'b0) begin
            errors++;
            $display("FAIL latch_latency got=%b want=0", nes_data);
        end
        tick(8);
        nes_latch = 1'b0;
        model_phase = ~model_phase;
        tick(6);
        nes_pulse = 1'b1;
        tick(SYNC + 1);
        checks++;
        if (nes_data !== 1'b0) begin
            errors++;
            $display("FAIL pulse_latency_early got=%b want=0", nes_data);
        end
        tick(1);
        checks++;
        if (nes_data !== 1'b1) begin
            errors++;
            $display("FAIL pulse_latency got=%b want=1", nes_data);
        end
        tick(2);
        nes_pulse = 1'b0;
        tick(6);
    endtask

    task automatic test_latch_pulse_overlap();
        logic [7:0] exp;
        int         fd;
        logic       fdd;
        buttons    = 8'($urandom) | 8'h01;
        turbo_mask = 2'b00;
        exp = expect_serial(buttons, turbo_mask, model_phase);
        nes_latch = 1'b1;
        nes_pulse = 1'b1;
        tick(6);
        nes_pulse = 1'b0;
        tick(6);
        nes_pulse = 1'b1;
        tick(6);
        nes_pulse = 1'b0;
        tick(6);
        nes_latch = 1'b0;
        model_phase = ~model_phase;
        tick(6);
        checks++;
        if (nes_data !== exp[0]) begin
            errors++;
            $display("FAIL overlap first_bit got=%b want=%b", nes_data, exp[0]);
        end
        do_pulse(fd, fdd);
        checks++;
        if (nes_data !== exp[1]) begin
            errors++;
            $display("FAIL overlap second_bit got=%b want=%b", nes_data, exp[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   fd;
        logic fdd;
        buttons    = 8'h00;
        turbo_mask = 2'b00;
        do_latch(12);
        for (int k = 0; k < 3; k++) do_pulse(fd, fdd);
        hard_reset = 1'b1;
        @(negedge clk);
        hard_reset = 1'b0;
        model_phase = 1'b0;
        checks++;
        if (nes_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid data/busy/fd got=%b%b%b want=100", nes_data, busy, frame_done);
        end
        for (int k = 0; k < 6; k++) begin
            do_pulse(fd, fdd);
            checks++;
            if (nes_data !== 1'b1 || busy !== 1'b0 || fd != 0) begin
                errors++;
                $display("FAIL reset_mid pulse%0d data=%b busy=%b fd=%0d want 1 0 0", k, nes_data, busy, fd);
            end
        end
    endtask

    task automatic test_turbo();
        logic [7:0] exp1, exp2;
        exp1 = expect_serial(8'h03, 2'b01, model_phase);
        exp2 = expect_serial(8'h03, 2'b01, ~model_phase);
        checks++;
        if (exp1[0] === exp2[0] && TURBO) begin
            errors++;
            $display("FAIL turbo_model phase not alternating got=%b%b", exp1[0], exp2[0]);
        end
        run_frame("turbo_f1", 8'h03, 2'b01, 1'b0);
        run_frame("turbo_f2", 8'h03, 2'b01, 1'b0);
        run_frame("turbo_f3", 8'h03, 2'b01, 1'b0);
    endtask

    initial begin
        test_reset();
        test_latency();
        run_frame("directed_85", 8'b1000_0101, 2'b00, 1'b0);
        run_frame("mid_change", 8'b0110_1001, 2'b00, 1'b1);
        test_latch_pulse_overlap();
        for (int r = 0; r < 6; r++)
            run_frame("random", 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        test_reset_mid_frame();
        test_turbo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
